// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and its datapath (slave).
// The instruction fields and status flags flow in; the sequenced control strobes flow out.
interface multicycle_controller_if #(
  parameter int OPW    = 3,
  parameter int FUNCTW = 4
);
  logic [OPW-1:0]    op;
  logic [FUNCTW-1:0] funct;
  logic              zero;
  logic              mem_ready;

  logic              memread;
  logic              memwrite;
  logic              iord;
  logic              irwrite;
  logic              regdst;
  logic              memtoreg;
  logic              regwrite;
  logic              alusrca;
  logic [1:0]        alusrcb;
  logic [FUNCTW-1:0] alucontrol;
  logic [1:0]        pcsrc;
  logic              pcen;
  logic              illegal;
  logic [3:0]        state;

  modport master (
    input  op, funct, zero, mem_ready,
    output memread, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, alucontrol, pcsrc, pcen, illegal, state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  memread, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, alucontrol, pcsrc, pcen, illegal, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing fetch/decode/execute/memory/writeback for the 16-bit multicycle core.
// Only the FETCH strobes (on mem_ready) and the branch PC enable (on zero) are Mealy.
module multicycle_controller #(
  parameter int                OPW     = 3,
  parameter int                FUNCTW  = 4,
  parameter logic [FUNCTW-1:0] ALU_ADD = 4'b0000,
  parameter logic [FUNCTW-1:0] ALU_SUB = 4'b0001
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    TRAP   = 4'd12
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(0);
  localparam logic [OPW-1:0] OP_LW    = OPW'(1);
  localparam logic [OPW-1:0] OP_SW    = OPW'(2);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(3);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(4);
  localparam logic [OPW-1:0] OP_J     = OPW'(5);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6);

  state_t state_reg;
  state_t state_next;
  logic   illegal_reg;

  logic              memread;
  logic              memwrite;
  logic              iord;
  logic              irwrite;
  logic              regdst;
  logic              memtoreg;
  logic              regwrite;
  logic              alusrca;
  logic [1:0]        alusrcb;
  logic [FUNCTW-1:0] alucontrol;
  logic [1:0]        pcsrc;
  logic              pcen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= FETCH;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_next == TRAP) begin
        illegal_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    memread    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = ALU_ADD;
    pcsrc      = 2'b00;
    pcen       = 1'b0;

    case (state_reg)
      FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        // Gated by rst_n so no write strobe can escape while reset is held.
        irwrite = bus.mem_ready & rst_n;
        pcen    = bus.mem_ready & rst_n;
        if (bus.mem_ready) begin
          state_next = DECODE;
        end
      end

      DECODE: begin
        alusrcb = 2'b11;
        case (bus.op)
          OP_RTYPE:      state_next = EXEC;
          OP_LW, OP_SW:  state_next = MEMADR;
          OP_BEQ, OP_BNE: state_next = BRANCH;
          OP_ADDI:       state_next = ADDIEX;
          OP_J:          state_next = JUMP;
          default:       state_next = TRAP;
        endcase
      end

      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = (bus.op == OP_LW) ? MEMRD : MEMWR;
      end

      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (bus.mem_ready) begin
          state_next = MEMWB;
        end
      end

      MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        state_next = FETCH;
      end

      MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready) begin
          state_next = FETCH;
        end
      end

      EXEC: begin
        alusrca    = 1'b1;
        alucontrol = bus.funct;
        state_next = ALUWB;
      end

      ALUWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        state_next = FETCH;
      end

      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = (bus.op == OP_BNE) ? ~bus.zero : bus.zero;
        state_next = FETCH;
      end

      ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = ADDIWB;
      end

      ADDIWB: begin
        regwrite   = 1'b1;
        state_next = FETCH;
      end

      JUMP: begin
        pcsrc      = 2'b10;
        pcen       = 1'b1;
        state_next = FETCH;
      end

      TRAP: begin
        state_next = TRAP;
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

  assign bus.memread    = memread;
  assign bus.memwrite   = memwrite;
  assign bus.iord       = iord;
  assign bus.irwrite    = irwrite;
  assign bus.regdst     = regdst;
  assign bus.memtoreg   = memtoreg;
  assign bus.regwrite   = regwrite;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.alucontrol = alucontrol;
  assign bus.pcsrc      = pcsrc;
  assign bus.pcen       = pcen;
  assign bus.illegal    = illegal_reg;
  assign bus.state      = state_reg;

  // The single memory port and the architectural write strobes must never collide.
  a_mem_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !(memread && memwrite));
  a_write_excl : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({regwrite, pcen, memwrite}));

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised multicycle successor to the single-cycle CPU controller for the 16-bit MIPS-style core.
- Replaces the combinational op/funct decode with a Moore FSM that sequences fetch, decode, execute, memory and writeback over multiple cycles, sharing one ALU and one memory port.
- Adds a memory ready handshake, BNE support and a sticky illegal-opcode trap.
- Sits between the instruction register and the multicycle datapath.

Parameters:
- OPW, 3, opcode field width.
- FUNCTW, 4, funct field width, which is also the alucontrol width.
- ALU_ADD, 4'b0000, alucontrol code driven for address/PC add.
- ALU_SUB, 4'b0001, alucontrol code driven for branch compare.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  OPW  opcode from the instruction register.
- funct  in  FUNCTW  funct field from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- irwrite  out  1  instruction register load.
- regdst  out  1  register write destination: 1=rd, 0=rt.
- memtoreg  out  1  write-back data select: 1=MDR, 0=ALUOut.
- regwrite  out  1  register file write enable.
- alusrca  out  1  ALU A select: 0=PC, 1=register A.
- alusrcb  out  2  ALU B select: 00=B, 01=const 1 (word step), 10=sign-extended imm, 11=branch offset.
- alucontrol  out  FUNCTW  ALU operation.
- pcsrc  out  2  PC select: 00=ALU result, 01=ALUOut, 10=jump target.
- pcen  out  1  PC write enable.
- illegal  out  1  sticky illegal-opcode flag.
- state  out  4  current FSM state, for debug.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=FETCH, illegal=0.
  - All outputs take their FETCH values below, with pcen=0 and irwrite=0 while mem_ready=0.
- Outputs are Moore, decoded from state, except where noted. Any output not listed for a state is 0, and alucontrol defaults to ALU_ADD.
- Opcode map:
  - 000 R-type, 001 LW, 010 SW, 011 BEQ, 100 ADDI, 101 J, 110 BNE, 111 illegal.
- FETCH (0):
  - Drives memread=1, iord=0, alusrca=0, alusrcb=01, ALU_ADD, pcsrc=00.
  - irwrite=mem_ready and pcen=mem_ready (Mealy on mem_ready).
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE (1):
  - Drives alusrca=0, alusrcb=11, ALU_ADD (precomputes branch target into ALUOut).
  - Next state by op: 000→EXEC, 001/010→MEMADR, 011/110→BRANCH, 100→ADDIEX, 101→JUMP, 111→TRAP.
- MEMADR (2):
  - Drives alusrca=1, alusrcb=10, ALU_ADD.
  - Goes to MEMRD if op=001, else MEMWR.
- MEMRD (3):
  - Drives memread=1, iord=1.
  - Holds until mem_ready=1, then goes to MEMWB.
- MEMWB (4):
  - Drives regwrite=1, memtoreg=1, regdst=0, then goes to FETCH.
- MEMWR (5):
  - Drives memwrite=1, iord=1, held stable until mem_ready=1, then goes to FETCH.
- EXEC (6):
  - Drives alusrca=1, alusrcb=00, alucontrol=funct, then goes to ALUWB.
- ALUWB (7):
  - Drives regwrite=1, regdst=1, memtoreg=0, then goes to FETCH.
- BRANCH (8):
  - Drives alusrca=1, alusrcb=00, ALU_SUB, pcsrc=01.
  - pcen=zero for BEQ and pcen=~zero for BNE (Mealy on zero).
  - Goes to FETCH.
- ADDIEX (9):
  - Drives alusrca=1, alusrcb=10, ALU_ADD, then goes to ADDIWB.
- ADDIWB (10):
  - Drives regwrite=1, regdst=0, memtoreg=0, then goes to FETCH.
- JUMP (11):
  - Drives pcsrc=10, pcen=1, then goes to FETCH.
- TRAP (12):
  - illegal=1, all enables 0; remains in TRAP until reset.
- Unused encodings 13–15 go to FETCH on the next clock and drive all enables to 0.
- Instruction latencies (mem_ready always 1):
  - R-type 4 cycles, LW 5, SW 4, ADDI 4, BEQ/BNE 3, J 3.
- Each memory wait cycle adds 1 cycle.
- memread and memwrite are never both 1. regwrite, pcen and memwrite are never asserted in the same cycle.
- op and funct are sampled only while state≠FETCH. The instruction register holds them stable after irwrite.
- A mid-instruction reset returns to FETCH immediately, with no write enable asserted after rst_n falls.

Test Plan:
- Reset, then hold mem_ready=0 for 3 cycles → state=0, memread=1, pcen=0 and irwrite=0 for those 3 cycles; pcen=irwrite=1 on the first mem_ready=1 cycle; state=1 after that edge.
- R-type op=000, funct=4'b0110, mem_ready=1 → states 0,1,6,7; alucontrol=0110 in EXEC; regwrite=1 and regdst=1 only in ALUWB.
- LW op=001 with mem_ready low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4; iord=1 throughout MEMRD; memtoreg=regwrite=1 in MEMWB.
- BEQ op=011 with zero=1 → pcen=1 and pcsrc=01 in BRANCH. BNE op=110 with zero=1 → pcen=0. BNE with zero=0 → pcen=1. alucontrol=ALU_SUB in all cases.
- J op=101 → states 0,1,11,0 with pcsrc=10 and pcen=1 in JUMP. Illegal op=111 → state 12, illegal=1, held for 10 cycles, cleared by rst_n=0.
- SW op=010 in MEMWR with rst_n pulsed low asynchronously → memwrite drops to 0 before the next clock edge; state=0; illegal=0.
